// File: rtl/row_format_pkg.sv
// rtl/row_format_pkg.sv - shared constants and helpers for the numeric display row
package row_format_pkg;

    localparam logic [1:0] MODE_HEX  = 2'd0;
    localparam logic [1:0] MODE_UDEC = 2'd1;
    localparam logic [1:0] MODE_SDEC = 2'd2;
    localparam logic [1:0] MODE_BIN  = 2'd3;

    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_HASH  = 8'd35;
    localparam logic [7:0] ASCII_MINUS = 8'd45;
    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_ALPHA = 8'd55;

    // Decimal digits needed for a w-bit unsigned value (log10(2) ~ 1233/4096).
    function automatic int decDigits(input int w);
        return ((w * 1233) >> 12) + 1;
    endfunction

    // Four-character label followed by the separating space.
    function automatic logic [7:0] label_char(input logic [1:0] m, input int idx);
        logic [31:0] text;
        case (m)
            MODE_HEX: text = "Hex:";
            MODE_BIN: text = "Bin:";
            default:  text = "Dec:";
        endcase
        case (idx)
            0:       return text[31:24];
            1:       return text[23:16];
            2:       return text[15:8];
            3:       return text[7:0];
            default: return ASCII_SPACE;
        endcase
    endfunction

    // One hex/decimal/binary digit to its ASCII glyph.
    function automatic logic [7:0] digit_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_ZERO + {4'd0, n};
        end
        return ASCII_ALPHA + {4'd0, n};
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential double-dabble binary to BCD converter
module bcd_converter
    import row_format_pkg::*;
#(
    parameter int VALUE_WIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    i_start,
    input  logic [VALUE_WIDTH-1:0]                  i_bin,
    output logic [4*decDigits(VALUE_WIDTH)-1:0]     o_bcd,
    output logic                                    o_done
);

    localparam int W     = VALUE_WIDTH;
    localparam int D     = decDigits(W);
    localparam int BCD_W = 4 * D;

    logic [W-1:0]     r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [5:0]       r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;

    assign o_bcd  = r_bcd;
    // High on the edge that performs the final shift; o_bcd is complete after it.
    assign o_done = r_active && (r_cnt == 6'd1);

    // Add-3 correction on every digit that would overflow when doubled.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < D; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then one corrected shift per cycle for W cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_bin    <= i_bin;
            r_bcd    <= '0;
            r_cnt    <= 6'(W);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[W-1]};
            r_bin <= {r_bin[W-2:0], 1'b0};
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/number_format_row.sv
// rtl/number_format_row.sv - formats one value into a labelled, right-justified text row
module number_format_row
    import row_format_pkg::*;
#(
    parameter int VALUE_WIDTH = 16,
    parameter int ROW_CHARS   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [VALUE_WIDTH-1:0]       value,
    input  logic [1:0]                   mode,
    input  logic                         blankZeros,
    input  logic                         update,
    input  logic [$clog2(ROW_CHARS)-1:0] outputCharIndex,
    output logic [7:0]                   outByte,
    output logic                         busy,
    output logic                         done
);

    localparam int W     = VALUE_WIDTH;
    localparam int F     = ROW_CHARS - 5;
    localparam int D     = decDigits(W);
    localparam int BCD_W = 4 * D;
    localparam int HEXD  = (W + 3) / 4;
    localparam int IDX_W = $clog2(ROW_CHARS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_CONVERT = 3'd2;
    localparam logic [2:0] ST_FORMAT  = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;

    logic [2:0]       r_state;
    logic             r_pending;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_value;
    logic [1:0]       r_mode;
    logic             r_blank;
    logic [IDX_W-1:0] r_k;
    logic [7:0]       r_shadow  [ROW_CHARS];
    logic [7:0]       r_display [ROW_CHARS];
    logic [7:0]       r_out;

    logic             w_is_dec_in;
    logic [W-1:0]     w_mag;
    logic             w_conv_start;
    logic             w_conv_done;
    logic [BCD_W-1:0] w_bcd;
    logic [BCD_W-1:0] w_src;
    logic             w_neg;
    int               w_sig;
    int               w_nd_full;
    int               w_nd;
    int               w_width;
    logic [3:0]       w_nib;
    logic [7:0]       w_field_char;
    logic [IDX_W-1:0] w_pos;

    assign busy    = r_busy;
    assign done    = r_done;
    assign outByte = r_out;

    // Magnitude of the live input, handed to the converter on the CAPTURE edge.
    always_comb begin
        w_is_dec_in  = (mode == MODE_UDEC) || (mode == MODE_SDEC);
        w_mag        = value;
        if ((mode == MODE_SDEC) && value[W-1]) begin
            w_mag = ~value + 1'b1;
        end
        w_conv_start = (r_state == ST_CAPTURE) && w_is_dec_in;
    end

    bcd_converter #(
        .VALUE_WIDTH (W)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_conv_start),
        .i_bin   (w_mag),
        .o_bcd   (w_bcd),
        .o_done  (w_conv_done)
    );

    // Field character for offset r_k counted from the right edge of the row.
    always_comb begin
        if ((r_mode == MODE_UDEC) || (r_mode == MODE_SDEC)) begin
            w_src = w_bcd;
        end else begin
            w_src = BCD_W'(r_value);
        end
        w_neg     = (r_mode == MODE_SDEC) && r_value[W-1];
        w_sig     = 1;
        w_nd_full = D;
        w_nib     = 4'd0;
        case (r_mode)
            MODE_HEX: begin
                w_nd_full = HEXD;
                for (int i = 0; i < HEXD; i++) begin
                    if (w_src[4*i +: 4] != 4'd0) w_sig = i + 1;
                end
            end
            MODE_BIN: begin
                w_nd_full = W;
                for (int i = 0; i < W; i++) begin
                    if (w_src[i]) w_sig = i + 1;
                end
            end
            default: begin
                for (int i = 0; i < D; i++) begin
                    if (w_src[4*i +: 4] != 4'd0) w_sig = i + 1;
                end
            end
        endcase
        if (r_mode == MODE_BIN) begin
            for (int i = 0; i < W; i++) begin
                if (int'(r_k) == i) w_nib = {3'b000, w_src[i]};
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                if (int'(r_k) == i) w_nib = w_src[4*i +: 4];
            end
        end
        w_nd    = r_blank ? w_sig : w_nd_full;
        w_width = w_nd + (w_neg ? 1 : 0);
        if (w_width > F) begin
            w_field_char = ASCII_HASH;
        end else if (int'(r_k) < w_nd) begin
            w_field_char = digit_ascii(w_nib);
        end else if (w_neg && (int'(r_k) == w_nd)) begin
            w_field_char = ASCII_MINUS;
        end else begin
            w_field_char = ASCII_SPACE;
        end
        w_pos = IDX_W'(ROW_CHARS - 1) - r_k;
    end

    // Job sequencer: capture, optional BCD conversion, field fill, atomic commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_value   <= '0;
            r_mode    <= MODE_HEX;
            r_blank   <= 1'b0;
            r_k       <= '0;
            for (int i = 0; i < ROW_CHARS; i++) begin
                r_shadow[i]  <= ASCII_SPACE;
                r_display[i] <= ASCII_SPACE;
            end
        end else begin
            r_done <= 1'b0;
            if (update && (r_state != ST_IDLE) && (r_state != ST_COMMIT)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (update) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_busy  <= 1'b1;
                    r_value <= value;
                    r_mode  <= mode;
                    r_blank <= blankZeros;
                    r_k     <= '0;
                    r_state <= w_is_dec_in ? ST_CONVERT : ST_FORMAT;
                end
                ST_CONVERT: begin
                    if (w_conv_done) r_state <= ST_FORMAT;
                end
                ST_FORMAT: begin
                    r_shadow[w_pos] <= w_field_char;
                    for (int i = 0; i < 5; i++) begin
                        r_shadow[i] <= label_char(r_mode, i);
                    end
                    r_k <= r_k + 1'b1;
                    if (r_k == IDX_W'(F - 1)) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_display <= r_shadow;
                    r_done    <= 1'b1;
                    r_pending <= 1'b0;
                    r_state   <= (r_pending || update) ? ST_CAPTURE : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered read port for the screen engine, independent of the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= ASCII_SPACE;
        end else if (int'(outputCharIndex) < ROW_CHARS) begin
            r_out <= r_display[outputCharIndex];
        end else begin
            r_out <= ASCII_SPACE;
        end
    end

endmodule

// File: tb/tb_number_format_row.sv
// tb/tb_number_format_row.sv - scoreboard bench for number_format_row
module tb_number_format_row;

    localparam int W  = 16;
    localparam int R  = 16;
    localparam int F  = R - 5;
    localparam int IW = 4;
    localparam int DD = ((W * 1233) >> 12) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  value;
    logic [1:0]    mode;
    logic          blankZeros;
    logic          update;
    logic [IW-1:0] outputCharIndex;
    logic [7:0]    outByte;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    number_format_row #(.VALUE_WIDTH(W), .ROW_CHARS(R)) dut (
        .clk             (clk),
        .reset           (reset),
        .value           (value),
        .mode            (mode),
        .blankZeros      (blankZeros),
        .update          (update),
        .outputCharIndex (outputCharIndex),
        .outByte         (outByte),
        .busy            (busy),
        .done            (done)
    );

    typedef struct packed {
        logic [R*8-1:0] row;
        int             dcyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   rd_req   = 0;
    int   rd_srv   = 0;
    bit   mon_busy = 1'b0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic byte digch(input int d);
        return (d < 10) ? byte'(48 + d) : byte'(55 + d);
    endfunction

    function automatic int job_len(input logic [1:0] m);
        return (m == 2'd1 || m == 2'd2) ? 2 + W + F : 2 + F;
    endfunction

    // Reference: build the row as a text string from the value's digits.
    function automatic logic [R*8-1:0] model_row(input logic [1:0] m, input logic [W-1:0] v, input logic b);
        logic [R*8-1:0] r;
        string  lab, s, all;
        int     base, full, nd;
        longint mag;
        bit     neg;
        int     digs[$];
        case (m)
            2'd0:    begin lab = "Hex:"; base = 16; full = (W + 3) / 4; end
            2'd3:    begin lab = "Bin:"; base = 2;  full = W;           end
            default: begin lab = "Dec:"; base = 10; full = DD;          end
        endcase
        neg = (m == 2'd2) && v[W-1];
        mag = neg ? (longint'(1) << W) - longint'(v) : longint'(v);
        for (int i = 0; i < full; i++) begin
            digs.push_back(int'(mag % base));
            mag = mag / base;
        end
        nd = full;
        if (b) begin
            nd = 1;
            for (int i = 0; i < full; i++) if (digs[i] != 0) nd = i + 1;
        end
        s = "";
        for (int i = nd - 1; i >= 0; i--) s = $sformatf("%s%c", s, digch(digs[i]));
        if (neg) s = {"-", s};
        if (s.len() > F) begin
            s = "";
            for (int i = 0; i < F; i++) s = {s, "#"};
        end
        while (s.len() < F) s = {" ", s};
        all = {lab, " ", s};
        for (int i = 0; i < R; i++) r[8*i +: 8] = all[i];
        return r;
    endfunction

    function automatic logic [R*8-1:0] blank_row();
        logic [R*8-1:0] r;
        for (int i = 0; i < R; i++) r[8*i +: 8] = 8'd32;
        return r;
    endfunction

    function automatic string row_str(input logic [R*8-1:0] r);
        string s = "";
        for (int i = 0; i < R; i++) s = $sformatf("%s%c", s, r[8*i +: 8]);
        return s;
    endfunction

    task automatic read_row(output logic [R*8-1:0] got);
        for (int i = 0; i < R; i++) begin
            outputCharIndex = IW'(i);
            @(negedge clk);
            got[8*i +: 8] = outByte;
        end
    endtask

    task automatic check_row(input logic [R*8-1:0] exp_row);
        logic [R*8-1:0] got;
        read_row(got);
        n_cmp++;
        if (got !== exp_row) begin
            n_err++;
            $display("FAIL row @%0d: got \"%s\" required \"%s\"", cyc, row_str(got), row_str(exp_row));
        end
    endtask

    // Monitor: pops an expectation on every done pulse or read request.
    initial begin
        exp_t e;
        outputCharIndex = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                mon_busy = 1'b1;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.dcyc) begin
                        n_err++;
                        $display("FAIL done_cycle: got %0d required %0d", cyc, e.dcyc);
                    end
                    check_row(e.row);
                end
                mon_busy = 1'b0;
            end else if (rd_req != rd_srv) begin
                mon_busy = 1'b1;
                e = sb.pop_front();
                check_row(e.row);
                rd_srv++;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic [W-1:0] v, input logic b, input bit push);
        exp_t e;
        value = v; mode = m; blankZeros = b; update = 1'b1;
        @(posedge clk); #1;
        update   = 1'b0;
        last_acc = cyc;
        if (push) begin
            e.row  = model_row(m, v, b);
            e.dcyc = last_acc + job_len(m);
            sb.push_back(e);
        end
    endtask

    task automatic request_read(input logic [R*8-1:0] r);
        exp_t e;
        e.row  = r;
        e.dcyc = -1;
        sb.push_back(e);
        rd_req++;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || rd_req != rd_srv || mon_busy || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: waited %0d cycles, required < 300 (pending=%0d)", t, sb.size());
        end
    endtask

    initial begin
        logic [1:0]   m;
        logic [W-1:0] v;
        logic         b;
        int           acc0;
        reset = 1'b1; update = 1'b0; value = '0; mode = 2'd0; blankZeros = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        request_read(blank_row());
        wait_idle();

        issue(2'd0, 16'h00AF, 1'b0, 1); wait_idle();
        issue(2'd0, 16'h00AF, 1'b1, 1); wait_idle();
        issue(2'd1, 16'd65535, 1'b0, 1); wait_idle();
        issue(2'd1, 16'd0, 1'b1, 1); wait_idle();
        issue(2'd2, 16'h8000, 1'b1, 1); wait_idle();
        issue(2'd2, 16'hFFFF, 1'b1, 1); wait_idle();
        issue(2'd3, 16'h0005, 1'b0, 1); wait_idle();
        issue(2'd3, 16'h0005, 1'b1, 1); wait_idle();
        issue(2'd0, 16'h0000, 1'b1, 1); wait_idle();

        // Two requests during a decimal job merge into one follow-on job.
        issue(2'd1, 16'd12345, 1'b0, 1);
        acc0 = last_acc;
        repeat (4) @(posedge clk); #1;
        v = W'($urandom);
        value = v; mode = 2'd2; blankZeros = 1'b1; update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
        repeat (3) @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
        begin
            exp_t e;
            e.row  = model_row(2'd2, v, 1'b1);
            e.dcyc = acc0 + job_len(2'd1) + job_len(2'd2);
            sb.push_back(e);
        end
        repeat (21) @(posedge clk); #1;
        check_bit("busy_at_pending_capture", busy, 1'b1);
        wait_idle();

        // Reset in the middle of a job aborts it and blanks the display.
        issue(2'd2, W'($urandom), 1'b1, 0);
        repeat (9) @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) @(posedge clk); #1;
        check_bit("busy_after_abort", busy, 1'b0);
        request_read(blank_row());
        wait_idle();

        for (int n = 0; n < 24; n++) begin
            m = 2'($urandom_range(0, 3));
            b = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            issue(m, v, b, 1);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: reached cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
